// File: rtl/uart_peripheral_pkg.sv
// Shared UART definitions: register offsets, CON bit positions, FSM state encodings.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package uart_peripheral_pkg;

    localparam logic [31:0] RXD_OFF = 32'h0000_0000;
    localparam logic [31:0] TXD_OFF = 32'h0000_0004;
    localparam logic [31:0] CON_OFF = 32'h0000_0008;

    localparam int CON_TX_FULL   = 0;
    localparam int CON_TX_BUSY   = 1;
    localparam int CON_RX_VALID  = 2;
    localparam int CON_OVERRUN   = 3;
    localparam int CON_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic [31:0] con_word(
        input logic frame_err,
        input logic overrun,
        input logic rx_valid,
        input logic tx_busy,
        input logic tx_full
    );
        logic [31:0] w;
        w                = '0;
        w[CON_FRAME_ERR] = frame_err;
        w[CON_OVERRUN]   = overrun;
        w[CON_RX_VALID]  = rx_valid;
        w[CON_TX_BUSY]   = tx_busy;
        w[CON_TX_FULL]   = tx_full;
        return w;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO with registered pointers and a combinational head output.
// Latency: a pushed entry is visible at the head one clock after the push edge.
// Backpressure: push while full is dropped, pop while empty is ignored.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped UART: TX FIFO feeding a serialiser, single-byte RX holding register.
// Latency: bus reads combinational; TXD write into idle path starts the frame next clock.
// Backpressure: TXD writes dropped while FIFO full; unread RX byte causes overrun.
module uart_peripheral
    import uart_peripheral_pkg::*;
#(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          BAUD      = 9600,
    parameter int          TX_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Device_Read,
    input  logic        Device_Write,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    output logic [31:0] Device_Read_Data,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int          DIV      = CLK_FREQ / BAUD;
    localparam int          CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [31:0] ADDR_RXD = BASE_ADDR + RXD_OFF;
    localparam logic [31:0] ADDR_TXD = BASE_ADDR + TXD_OFF;
    localparam logic [31:0] ADDR_CON = BASE_ADDR + CON_OFF;

    logic sel_rxd, sel_txd, sel_con;
    logic wr_txd, wr_con, rd_rxd;
    logic unused_wdata;

    assign sel_rxd      = (MemBus_Address == ADDR_RXD);
    assign sel_txd      = (MemBus_Address == ADDR_TXD);
    assign sel_con      = (MemBus_Address == ADDR_CON);
    assign wr_txd       = Device_Write && sel_txd;
    assign wr_con       = Device_Write && sel_con;
    assign rd_rxd       = Device_Read && sel_rxd;
    assign unused_wdata = ^MemBus_Write_Data[31:8];

    // ---------------- transmit path ----------------
    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_bit_end;
    logic          tx_pop;
    logic [7:0]    tx_pop_dat;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_busy;

    uart_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_txd),
        .push_dat (MemBus_Write_Data[7:0]),
        .pop      (tx_pop),
        .pop_dat  (tx_pop_dat),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    assign tx_bit_end = (tx_cnt == CNT_LAST);
    // Pop from idle, or at the end of a stop bit so frames run back-to-back.
    assign tx_pop     = !tx_empty && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));
    assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_sh    <= tx_pop_dat;
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_sh[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            uart_tx <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_sh    <= tx_pop_dat;
                            uart_tx  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receive path ----------------
    logic          rx_s1, rx_s2, rx_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          overrun;
    logic          frame_err;
    logic          rx_stop_end;
    logic          rx_done_ok;
    logic          rx_done_bad;

    assign rx_stop_end = (rx_state == RX_STOP) && (rx_cnt == CNT_LAST);
    assign rx_done_ok  = rx_stop_end && rx_s2;
    assign rx_done_bad = rx_stop_end && !rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase

            // A read of RXD in the completion cycle frees the register for the new byte.
            if (rx_done_ok && (!rx_valid || rd_rxd)) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid <= 1'b0;
            end

            if (rx_done_ok && rx_valid && !rd_rxd)              overrun <= 1'b1;
            else if (wr_con && MemBus_Write_Data[CON_OVERRUN])   overrun <= 1'b0;

            if (rx_done_bad)                                     frame_err <= 1'b1;
            else if (wr_con && MemBus_Write_Data[CON_FRAME_ERR]) frame_err <= 1'b0;
        end
    end

    // ---------------- bus read mux ----------------
    always_comb begin
        Device_Read_Data = '0;
        if (Device_Read) begin
            if (sel_rxd)      Device_Read_Data = {24'b0, rx_byte};
            else if (sel_con) Device_Read_Data = con_word(frame_err, overrun, rx_valid, tx_busy, tx_full);
        end
    end

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed self-checking bench for uart_peripheral with DIV = 16 clocks per bit.
module tb_uart_peripheral;
    localparam int          DIV   = 16;
    localparam int          FRAME = DIV * 10;
    localparam logic [31:0] A_RXD = 32'h4000_0018;
    localparam logic [31:0] A_TXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Device_Read = 1'b0;
    logic        Device_Write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;
    int rx_lat = 11;

    uart_peripheral #(
        .CLK_FREQ  (16),
        .BAUD      (1),
        .TX_DEPTH  (4),
        .BASE_ADDR (32'h4000_0018)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Device_Read       (Device_Read),
        .Device_Write      (Device_Write),
        .MemBus_Address    (addr),
        .MemBus_Write_Data (wdata),
        .Device_Read_Data  (rdata),
        .uart_rx           (uart_rx),
        .uart_tx           (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // All bus tasks start and end on a falling clock edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Device_Write = 1'b1;
        addr         = a;
        wdata        = d;
        @(negedge clk);
        Device_Write = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        Device_Read = 1'b1;
        addr        = a;
        #1;
        d           = rdata;
        Device_Read = 1'b0;
    endtask

    task automatic read_clear(input logic [31:0] a, output logic [31:0] d);
        Device_Read = 1'b1;
        addr        = a;
        #1;
        d = rdata;
        @(negedge clk);
        Device_Read = 1'b0;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Expected line level k clocks after the first TXD write edge.
    function automatic logic fifo_exp(input int k, input int nfr, input logic [7:0] base);
        int         f;
        int         b;
        logic [7:0] byt;
        if (k < 1 || k > nfr * FRAME) return 1'b1;
        f   = (k - 1) / FRAME;
        b   = ((k - 1) % FRAME) / DIV;
        byt = base + 8'(f);
        return exp_bit(byt, b);
    endfunction

    task automatic send_rx_bits(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cycles(DIV);
        end
        uart_rx = stop;
    endtask

    task automatic send_rx(input logic [7:0] b);
        send_rx_bits(b, 1'b1);
        cycles(DIV);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int          bad;
        cycles(3);
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_con: got %h want %h", d, 32'h0); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        reset = 1'b1;
        cycles(2);
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_con: got %h want %h", d, 32'h0); end
        bus_write(A_TXD, 32'h00);
        bus_write(A_TXD, 32'h00);
        cycles(39);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_tx: got %b want 0", uart_tx); end
        #2 reset = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", uart_tx); end
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL in_reset_con: got %h want %h", d, 32'h0); end
        @(negedge clk);
        reset = 1'b1;
        cycles(1);
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL fifo_flushed_con: got %h want %h", d, 32'h0); end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_after_reset: %0d low samples, want 0", bad); end
    endtask

    task automatic test_tx;
        logic [31:0] d;
        int          bad;
        bus_write(A_TXD, 32'hA5);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_write_edge: got %b want 1", uart_tx); end
        peek(A_CON, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL tx_busy_start: got %h want %h", d, 32'h2); end
        bad = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (uart_tx !== exp_bit(8'hA5, (k - 1) / DIV)) begin
                if (bad == 0) $display("FAIL tx_a5_bit: clock %0d got %b want %b", k, uart_tx, exp_bit(8'hA5, (k - 1) / DIV));
                bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tx_a5_frame: %0d wrong samples, want 0", bad); end
        peek(A_CON, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL tx_busy_in_stop: got %h want %h", d, 32'h2); end
        @(negedge clk);
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_busy_end: got %h want %h", d, 32'h0); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle_end: got %b want 1", uart_tx); end
    endtask

    task automatic run_fifo(input int nwr, input logic [7:0] base);
        logic [31:0] d;
        int          bad;
        int          nfr;
        nfr = (nwr > 5) ? 5 : nwr;
        bad = 0;
        for (int i = 0; i < nwr; i++) begin
            bus_write(A_TXD, {24'b0, base + 8'(i)});
            if (uart_tx !== fifo_exp(i, nfr, base)) bad++;
            if (i == 4) begin
                peek(A_CON, d);
                checks++; if (d !== 32'h3) begin errors++; $display("FAIL fifo_full_%0d: got %h want %h", nwr, d, 32'h3); end
            end
        end
        for (int k = nwr; k <= nfr * FRAME + 20; k++) begin
            @(negedge clk);
            if (uart_tx !== fifo_exp(k, nfr, base)) begin
                if (bad == 0) $display("FAIL fifo_bit_%0d: clock %0d got %b want %b", nwr, k, uart_tx, fifo_exp(k, nfr, base));
                bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL fifo_frames_%0d: %0d wrong samples, want 0", nwr, bad); end
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL fifo_drained_%0d: got %h want %h", nwr, d, 32'h0); end
    endtask

    task automatic test_fifo;
        run_fifo(5, 8'h01);
        run_fifo(6, 8'h11);
    endtask

    task automatic test_rx;
        logic [31:0] d;
        int          n;
        send_rx_bits(8'h3C, 1'b1);
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_not_early: got %h want %h", d, 32'h0); end
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            @(negedge clk);
            peek(A_CON, d);
            if (d[2] === 1'b1) n = i;
        end
        checks++;
        if (n < 8 || n > 18) begin
            errors++; $display("FAIL rx_valid_latency: got %0d clocks after stop start, want 8..18", n);
        end else begin
            rx_lat = n;
        end
        if (n > 0 && n < DIV) cycles(DIV - n);
        peek(A_RXD, d);
        checks++; if (d !== 32'h3C) begin errors++; $display("FAIL rx_peek: got %h want %h", d, 32'h3C); end
        bus_write(A_RXD, 32'hFF);
        addr = A_RXD;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL no_read_strobe: got %h want 0", rdata); end
        peek(A_TXD, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txd_read: got %h want 0", d); end
        peek(32'h4000_001A, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL partial_addr: got %h want 0", d); end
        peek(32'h4000_0024, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_addr: got %h want 0", d); end
        @(negedge clk);
        read_clear(A_RXD, d);
        checks++; if (d !== 32'h3C) begin errors++; $display("FAIL rx_read: got %h want %h", d, 32'h3C); end
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_cleared: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_errors;
        logic [31:0] d;
        send_rx(8'h55);
        send_rx(8'hAA);
        peek(A_CON, d);
        checks++; if (d !== 32'h0C) begin errors++; $display("FAIL overrun_con: got %h want %h", d, 32'h0C); end
        peek(A_RXD, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL overrun_keeps: got %h want %h", d, 32'h55); end
        send_rx_bits(8'h99, 1'b0);
        cycles(DIV);
        uart_rx = 1'b1;
        cycles(DIV);
        peek(A_CON, d);
        checks++; if (d !== 32'h1C) begin errors++; $display("FAIL frame_err_con: got %h want %h", d, 32'h1C); end
        peek(A_RXD, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL frame_err_discard: got %h want %h", d, 32'h55); end
        bus_write(A_CON, 32'h18);
        peek(A_CON, d);
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL w1c_con: got %h want %h", d, 32'h04); end
        read_clear(A_RXD, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL err_read: got %h want %h", d, 32'h55); end
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_all_clear: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        uart_rx = 1'b0;
        cycles(4);
        uart_rx = 1'b1;
        cycles(12 * DIV);
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_con: got %h want %h", d, 32'h0); end
        peek(A_RXD, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL glitch_rxd: got %h want %h", d, 32'h55); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        send_rx(8'h81);
        peek(A_CON, d);
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL collide_first: got %h want %h", d, 32'h04); end
        send_rx_bits(8'h7E, 1'b1);
        cycles(rx_lat - 1);
        read_clear(A_RXD, d);
        checks++; if (d !== 32'h81) begin errors++; $display("FAIL collide_read: got %h want %h", d, 32'h81); end
        peek(A_CON, d);
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL collide_con: got %h want %h", d, 32'h04); end
        peek(A_RXD, d);
        checks++; if (d !== 32'h7E) begin errors++; $display("FAIL collide_new_byte: got %h want %h", d, 32'h7E); end
        if (rx_lat < DIV) cycles(DIV - rx_lat);
        read_clear(A_RXD, d);
        checks++; if (d !== 32'h7E) begin errors++; $display("FAIL collide_final_read: got %h want %h", d, 32'h7E); end
        peek(A_CON, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL collide_clear: got %h want %h", d, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_fifo();
        test_rx();
        test_errors();
        test_glitch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
